// File: rtl/ex_stage.sv
// ============================================================================
//  Module  : ex_stage
//  Brief   : MIPS32 execute stage with HI/LO forwarding and a 2-cycle MADD/MSUB
//            sequence; optional stall-cycle counter enabled by EX_STALL_CNT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    input  logic        wb_whilo_i,
    input  logic [63:0] hilo_temp_i,
    input  logic [1:0]  cnt_i,
    input  logic [31:0] link_address_i,
    input  logic        is_in_delay_slot_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [63:0] hilo_temp_o,
    output logic [1:0]  cnt_o,
`ifdef EX_STALL_CNT_EN
    output logic [31:0] stall_cycles_o,
`endif
    output logic        stallreq_from_ex
);

    localparam logic [2:0] C_SEL_NOP   = 3'b000;
    localparam logic [2:0] C_SEL_LOGIC = 3'b001;
    localparam logic [2:0] C_SEL_SHIFT = 3'b010;
    localparam logic [2:0] C_SEL_MOVE  = 3'b011;
    localparam logic [2:0] C_SEL_ARITH = 3'b100;
    localparam logic [2:0] C_SEL_MUL   = 3'b101;
    localparam logic [2:0] C_SEL_JB    = 3'b110;

    localparam logic [7:0] C_AND = 8'h24, C_OR = 8'h25, C_XOR = 8'h26, C_NOR = 8'h27;
    localparam logic [7:0] C_SLL = 8'h7C, C_SRL = 8'h02, C_SRA = 8'h03;
    localparam logic [7:0] C_MFHI = 8'h10, C_MTHI = 8'h11, C_MFLO = 8'h12, C_MTLO = 8'h13;
    localparam logic [7:0] C_MOVZ = 8'h0A, C_MOVN = 8'h0B;
    localparam logic [7:0] C_ADD = 8'h20, C_ADDU = 8'h21, C_SUB = 8'h22, C_SUBU = 8'h23;
    localparam logic [7:0] C_ADDI = 8'h55, C_ADDIU = 8'h56, C_SLT = 8'h2A, C_SLTU = 8'h2B;
    localparam logic [7:0] C_CLZ = 8'hB0, C_CLO = 8'hB1;
    localparam logic [7:0] C_MULT = 8'h18, C_MULTU = 8'h19, C_MUL = 8'hA9;
    localparam logic [7:0] C_MADD = 8'hA6, C_MADDU = 8'hA8, C_MSUB = 8'hAA, C_MSUBU = 8'hAB;

    logic [31:0] w_hi, w_lo;
    logic [31:0] w_opnd2, w_sum;
    logic        w_sub, w_ov;
    logic [5:0]  w_clz, w_clo;
    logic        w_mul_signed, w_neg;
    logic [31:0] w_mag1, w_mag2;
    logic [63:0] w_prod_mag, w_prod, w_madd_sum;
    logic        w_is_madd, w_is_msub;

    // MEM holds the younger HI/LO write, so it takes priority over WB
    assign w_hi = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    assign w_lo = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

    assign w_sub   = (aluop_i == C_SUB) || (aluop_i == C_SUBU);
    assign w_opnd2 = w_sub ? (~reg2_i + 32'd1) : reg2_i;
    assign w_sum   = reg1_i + w_opnd2;

    always_comb begin
        w_ov = 1'b0;
        if (aluop_i == C_ADD || aluop_i == C_ADDI)
            w_ov = (reg1_i[31] == reg2_i[31]) && (w_sum[31] != reg1_i[31]);
        else if (aluop_i == C_SUB)
            w_ov = (reg1_i[31] != reg2_i[31]) && (w_sum[31] != reg1_i[31]);
    end

    // Highest matching bit wins because later loop iterations overwrite earlier ones
    always_comb begin
        w_clz = 6'd32;
        w_clo = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (reg1_i[i])  w_clz = 6'(31 - i);
            if (!reg1_i[i]) w_clo = 6'(31 - i);
        end
    end

    assign w_mul_signed = (aluop_i == C_MULT) || (aluop_i == C_MUL) ||
                          (aluop_i == C_MADD) || (aluop_i == C_MSUB);
    assign w_mag1     = (w_mul_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign w_mag2     = (w_mul_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    assign w_prod_mag = {32'd0, w_mag1} * {32'd0, w_mag2};
    assign w_neg      = w_mul_signed && (reg1_i[31] ^ reg2_i[31]);
    assign w_prod     = w_neg ? (~w_prod_mag + 64'd1) : w_prod_mag;

    assign w_is_msub  = (aluop_i == C_MSUB) || (aluop_i == C_MSUBU);
    assign w_is_madd  = (aluop_i == C_MADD) || (aluop_i == C_MADDU) || w_is_msub;
    assign w_madd_sum = hilo_temp_i + {w_hi, w_lo};

    always_comb begin
        hi_o             = 32'd0;
        lo_o             = 32'd0;
        whilo_o          = 1'b0;
        wd_o             = 5'd0;
        wreg_o           = 1'b0;
        wdata_o          = 32'd0;
        hilo_temp_o      = 64'd0;
        cnt_o            = 2'd0;
        stallreq_from_ex = 1'b0;
        if (rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i && !w_ov;
            case (alusel_i)
                C_SEL_LOGIC: begin
                    case (aluop_i)
                        C_AND:   wdata_o = reg1_i & reg2_i;
                        C_OR:    wdata_o = reg1_i | reg2_i;
                        C_XOR:   wdata_o = reg1_i ^ reg2_i;
                        C_NOR:   wdata_o = ~(reg1_i | reg2_i);
                        default: wdata_o = 32'd0;
                    endcase
                end
                C_SEL_SHIFT: begin
                    case (aluop_i)
                        C_SLL:   wdata_o = reg2_i << reg1_i[4:0];
                        C_SRL:   wdata_o = reg2_i >> reg1_i[4:0];
                        C_SRA:   wdata_o = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
                        default: wdata_o = 32'd0;
                    endcase
                end
                C_SEL_MOVE: begin
                    case (aluop_i)
                        C_MFHI:         wdata_o = w_hi;
                        C_MFLO:         wdata_o = w_lo;
                        C_MOVZ, C_MOVN: wdata_o = reg1_i;
                        default:        wdata_o = 32'd0;
                    endcase
                end
                C_SEL_ARITH: begin
                    case (aluop_i)
                        C_ADD, C_ADDU, C_SUB, C_SUBU, C_ADDI, C_ADDIU: wdata_o = w_sum;
                        C_SLT:   wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                        C_SLTU:  wdata_o = {31'd0, reg1_i < reg2_i};
                        C_CLZ:   wdata_o = {26'd0, w_clz};
                        C_CLO:   wdata_o = {26'd0, w_clo};
                        default: wdata_o = 32'd0;
                    endcase
                end
                C_SEL_MUL: wdata_o = w_prod[31:0];
                C_SEL_JB:  wdata_o = link_address_i;
                C_SEL_NOP: wdata_o = 32'd0;
                default:   wdata_o = 32'd0;
            endcase

            if (aluop_i == C_MTHI) begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = w_lo;
            end else if (aluop_i == C_MTLO) begin
                whilo_o = 1'b1;
                hi_o    = w_hi;
                lo_o    = reg1_i;
            end else if (aluop_i == C_MULT || aluop_i == C_MULTU) begin
                whilo_o      = 1'b1;
                {hi_o, lo_o} = w_prod;
            end else if (w_is_madd) begin
                // First pass latches the product in EX/MEM; second pass accumulates
                if (cnt_i == 2'd0) begin
                    hilo_temp_o      = w_is_msub ? (~w_prod + 64'd1) : w_prod;
                    cnt_o            = 2'd1;
                    stallreq_from_ex = 1'b1;
                end else if (cnt_i == 2'd1) begin
                    whilo_o      = 1'b1;
                    {hi_o, lo_o} = w_madd_sum;
                    cnt_o        = 2'd2;
                end
            end
        end
    end

`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stallreq_from_ex) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cycles_q <= 32'd0;
        else      stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles_o = stall_cycles_q;

    logic w_unused_ok;
    assign w_unused_ok = is_in_delay_slot_i;
`else
    logic w_unused_ok;
    assign w_unused_ok = clk ^ is_in_delay_slot_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
//  Module  : tb_ex_stage
//  Brief   : Directed self-checking bench for ex_stage using an expectation queue.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic        mem_whilo_i, wb_whilo_i;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic [31:0] link_address_i;
    logic        is_in_delay_slot_i;
    logic [31:0] hi_o, lo_o, wdata_o;
    logic        whilo_o, wreg_o, stallreq_from_ex;
    logic [4:0]  wd_o;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cycles_o;
`endif

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .mem_whilo_i(mem_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .wb_whilo_i(wb_whilo_i), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .link_address_i(link_address_i), .is_in_delay_slot_i(is_in_delay_slot_i),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o),
`ifdef EX_STALL_CNT_EN
        .stall_cycles_o(stall_cycles_o),
`endif
        .stallreq_from_ex(stallreq_from_ex)
    );

    typedef enum int {S_WDATA, S_WREG, S_HI, S_LO, S_WHILO, S_STALL, S_CNT, S_TEMP, S_WD} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [63:0] exp;
    } exp_t;

    exp_t scb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] observe(sel_e s);
        case (s)
            S_WDATA: return {32'd0, wdata_o};
            S_WREG:  return {63'd0, wreg_o};
            S_HI:    return {32'd0, hi_o};
            S_LO:    return {32'd0, lo_o};
            S_WHILO: return {63'd0, whilo_o};
            S_STALL: return {63'd0, stallreq_from_ex};
            S_CNT:   return {62'd0, cnt_o};
            S_TEMP:  return hilo_temp_o;
            default: return {59'd0, wd_o};
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_e s, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.sel = s; e.exp = v;
        scb.push_back(e);
    endtask

    // Outputs settle combinationally; sample 1 time unit after driving, off the clock edge
    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        #1;
        while (scb.size() > 0) begin
            e   = scb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic op(input logic [2:0] sel, input logic [7:0] code,
                      input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alusel_i = sel; aluop_i = code; reg1_i = a; reg2_i = b;
    endtask

    initial begin
        rst = 1'b0;
        aluop_i = 8'hA6; alusel_i = 3'b101; reg1_i = 32'h2; reg2_i = 32'h3;
        wd_i = 5'd7; wreg_i = 1'b1;
        hi_i = 32'h1234; lo_i = 32'h5678; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
        mem_whilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0; wb_whilo_i = 1'b0;
        hilo_temp_i = 64'h0; cnt_i = 2'd0; link_address_i = 32'h1C;
        is_in_delay_slot_i = 1'b0;

        // Held in reset: a first-pass MADD would otherwise stall and emit a partial product
        @(negedge clk);
        expect_val("rst_wdata", S_WDATA, 64'h0);
        expect_val("rst_wreg",  S_WREG,  64'h0);
        expect_val("rst_wd",    S_WD,    64'h0);
        expect_val("rst_stall", S_STALL, 64'h0);
        expect_val("rst_cnt",   S_CNT,   64'h0);
        expect_val("rst_temp",  S_TEMP,  64'h0);
        expect_val("rst_hi",    S_HI,    64'h0);
        expect_val("rst_whilo", S_WHILO, 64'h0);
        drain();

        rst = 1'b1;
        op(3'b100, 8'h20, 32'h7FFFFFFF, 32'h1);
        expect_val("add_ov_wreg", S_WREG, 64'h0);
        expect_val("add_ov_wd",   S_WD,   64'h7);
        drain();

        op(3'b100, 8'h21, 32'h7FFFFFFF, 32'h1);
        expect_val("addu_wdata", S_WDATA, 64'h80000000);
        expect_val("addu_wreg",  S_WREG,  64'h1);
        drain();

        op(3'b100, 8'h22, 32'h80000000, 32'h1);
        expect_val("sub_ov_wreg", S_WREG, 64'h0);
        drain();

        op(3'b100, 8'h2A, 32'hFFFFFFFF, 32'h1);
        expect_val("slt", S_WDATA, 64'h1);
        drain();
        op(3'b100, 8'h2B, 32'hFFFFFFFF, 32'h1);
        expect_val("sltu", S_WDATA, 64'h0);
        drain();

        op(3'b011, 8'h10, 32'h0, 32'h0);
        hi_i = 32'h1; wb_hi_i = 32'h2; wb_whilo_i = 1'b1; mem_hi_i = 32'h3; mem_whilo_i = 1'b1;
        expect_val("mfhi_mem", S_WDATA, 64'h3);
        drain();
        mem_whilo_i = 1'b0;
        expect_val("mfhi_wb", S_WDATA, 64'h2);
        drain();
        wb_whilo_i = 1'b0;
        expect_val("mfhi_arch", S_WDATA, 64'h1);
        drain();

        op(3'b101, 8'h18, 32'hFFFFFFFE, 32'h3);
        expect_val("mult_hi",    S_HI,    64'hFFFFFFFF);
        expect_val("mult_lo",    S_LO,    64'hFFFFFFFA);
        expect_val("mult_whilo", S_WHILO, 64'h1);
        drain();
        op(3'b101, 8'h19, 32'hFFFFFFFE, 32'h3);
        expect_val("multu_hi", S_HI, 64'h2);
        expect_val("multu_lo", S_LO, 64'hFFFFFFFA);
        drain();

        hi_i = 32'h0; lo_i = 32'h10;
        op(3'b101, 8'hA6, 32'h2, 32'h3);
        cnt_i = 2'd0; hilo_temp_i = 64'h0;
        expect_val("madd0_stall", S_STALL, 64'h1);
        expect_val("madd0_cnt",   S_CNT,   64'h1);
        expect_val("madd0_temp",  S_TEMP,  64'h6);
        expect_val("madd0_whilo", S_WHILO, 64'h0);
        drain();
        @(negedge clk);
        cnt_i = 2'd1; hilo_temp_i = 64'h6;
        expect_val("madd1_lo",    S_LO,    64'h16);
        expect_val("madd1_hi",    S_HI,    64'h0);
        expect_val("madd1_stall", S_STALL, 64'h0);
        expect_val("madd1_cnt",   S_CNT,   64'h2);
        expect_val("madd1_whilo", S_WHILO, 64'h1);
        drain();

        op(3'b101, 8'hAA, 32'h2, 32'h3);
        cnt_i = 2'd0; hilo_temp_i = 64'h0;
        expect_val("msub0_temp", S_TEMP, 64'hFFFFFFFF_FFFFFFFA);
        drain();
        cnt_i = 2'd3;
        expect_val("msub3_stall", S_STALL, 64'h0);
        expect_val("msub3_whilo", S_WHILO, 64'h0);
        drain();
        cnt_i = 2'd0;

        op(3'b100, 8'hB0, 32'h00010000, 32'h0);
        expect_val("clz", S_WDATA, 64'd15);
        drain();
        op(3'b100, 8'hB1, 32'hFFFFFFFF, 32'h0);
        expect_val("clo", S_WDATA, 64'd32);
        drain();
        op(3'b010, 8'h03, 32'h4, 32'h80000000);
        expect_val("sra", S_WDATA, 64'hF8000000);
        drain();
        op(3'b110, 8'h00, 32'h0, 32'h0);
        expect_val("jump_link", S_WDATA, 64'h1C);
        drain();

        op(3'b011, 8'h11, 32'hAB, 32'h0);
        lo_i = 32'hCD;
        expect_val("mthi_hi",    S_HI,    64'hAB);
        expect_val("mthi_lo",    S_LO,    64'hCD);
        expect_val("mthi_whilo", S_WHILO, 64'h1);
        drain();

        op(3'b001, 8'h27, 32'hF0F0F0F0, 32'h0F0F0000);
        expect_val("nor", S_WDATA, 64'h00000F0F);
        drain();

        // Reset reasserted mid-MADD drops the partial product immediately
        op(3'b101, 8'hA6, 32'h2, 32'h3);
        rst = 1'b0;
        expect_val("rst_mid_stall", S_STALL, 64'h0);
        expect_val("rst_mid_temp",  S_TEMP,  64'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
